imm_pipe: RTL and testbench
===========================

# imm_pipe

Registered, parametrised immediate generator for the decode stage of the RISC-V core. It extracts and sign-extends the instruction immediate for XLEN 32 or 64, adds two operand modes (zero-extended CSR immediate, shift amount), and computes `PC + IMM` for branch and jump targets. Results are delivered through a valid/ready pipeline stage with a two-entry skid buffer, so decode-to-execute backpressure does not create a combinational path back to fetch.

## Interface
- `XLEN`, 32: datapath width; legal values are 32 and 64 only.
- `CLK`  in  1  sole clock, rising edge.
- `RESETN`  in  1  reset, asynchronous, active-low.
- `FLUSH`  in  1  synchronous pipeline flush; discards all held entries.
- `IN_VALID`  in  1  upstream entry valid.
- `IN_READY`  out  1  stage can accept; registered output.
- `IN_INSTR`  in  32  instruction word.
- `IN_MODE`  in  4  immediate mode (`IMM_*` code).
- `IN_PC`  in  XLEN  instruction address.
- `OUT_VALID`  out  1  output entry valid.
- `OUT_READY`  in  1  downstream accepts.
- `OUT_IMM`  out  XLEN  generated immediate.
- `OUT_TARGET`  out  XLEN  `PC + IMM`, modulo 2^XLEN.
- `OUT_INSTR`  out  32  instruction passthrough.
- `OUT_ERR`  out  1  mode code was illegal; `OUT_IMM` is 0.

## Operation
- Mode codes and results:
  - ZERO=0 gives 0.
  - I=1, S=2, B=3, U=4, J=5: standard RISC-V layouts, sign-extended from INSTR[31] to XLEN. U-type places INSTR[31:12] in bits 31:12 and sign-extends from bit 31 when XLEN=64.
  - CONST_4=6 gives 4.
  - ZIMM=7: INSTR[19:15], zero-extended.
  - SHAMT=8: INSTR[24:20] when XLEN=32; INSTR[25:20] when XLEN=64; zero-extended.
  - Codes 9–15 are illegal: IMM=0 and ERR=1.
- Each accepted entry captures IMM, TARGET, INSTR and ERR together. All are computed combinationally from the inputs and registered on acceptance.
- Acceptance occurs when `IN_VALID && IN_READY`. Transfer occurs when `OUT_VALID && OUT_READY`.
- State machine: EMPTY (no entries), ONE (output register full), TWO (output and skid registers full).
  - EMPTY: accept → ONE.
  - ONE: accept and transfer → ONE, new entry in the output register. Accept without transfer → TWO, new entry in the skid register. Transfer without accept → EMPTY.
  - TWO: transfer → ONE, skid entry moves to the output register. No accept is possible in TWO.
- `IN_READY` = (next state ≠ TWO), registered. `OUT_VALID` = (state ≠ EMPTY).
- Ordering is strictly FIFO.
- FLUSH has priority over every event: next state is EMPTY and any input accepted in the same cycle is discarded.
- Reset state: EMPTY, `IN_READY`=1, `OUT_VALID`=0, and `OUT_IMM`, `OUT_TARGET`, `OUT_INSTR`, `OUT_ERR` all 0. Reset mid-operation drops all entries immediately (asynchronous assertion).
- Data outputs hold stable while `OUT_VALID && !OUT_READY`.

## Timing
- Latency: an entry accepted at edge N is visible on `OUT_*` with `OUT_VALID`=1 after edge N.
- Throughput: one entry per cycle while `OUT_READY` is held at 1.
- No combinational path from `OUT_READY` to `IN_READY`, or from any input to any output.
- Critical path: immediate mux followed by the XLEN-bit adder into the capture registers.

## Structure
- Mode codes `IMM_ZERO`..`IMM_SHAMT` and `IMM_MODE_W`=4 live in the shared `proc_defines.v`. The existing 3-bit codes keep their values, zero-extended to 4 bits.
- Sub-module `imm_extract`: purely combinational (INSTR, MODE, XLEN) → (IMM, ERR). The skid FSM and adder stay in `imm_pipe`.

## Test plan
- Directed scenarios:
  - I-type, XLEN=32: INSTR=0xFFF00093, MODE=1, PC=0 → `OUT_IMM`=0xFFFFFFFF, `OUT_TARGET`=0xFFFFFFFF, `OUT_VALID` one cycle after accept.
  - B-type wrap: INSTR=0xFE000EE3, MODE=3, PC=0x100 → `OUT_IMM`=0xFFFFFFFC, `OUT_TARGET`=0x000000FC.
  - U-type, XLEN=64: INSTR=0x800000B7, MODE=4 → `OUT_IMM`=0xFFFFFFFF80000000. Same word with MODE=8 → `OUT_IMM`=0 (SHAMT of bits 25:20). MODE=12 → `OUT_ERR`=1, `OUT_IMM`=0.
  - Backpressure: `OUT_READY`=0, then accept entries A and B.
    - `IN_READY` falls after B; C is held.
    - Raise `OUT_READY`: A, B, C emerge in order on consecutive cycles with no loss or duplication.
  - Flush in TWO: assert FLUSH with `IN_VALID`=1 → next cycle `OUT_VALID`=0 and `IN_READY`=1; neither held entry nor the input reappears.
  - Reset mid-stream: drop `RESETN` asynchronously while in ONE → outputs go to 0 and `IN_READY`=1 before the next edge. After release, the first accepted entry appears after one cycle.

Source files
------------

// File: rtl/imm_pipe_pkg.sv
// Shared definitions for the immediate pipeline: mode codes and skid-buffer states.
package imm_pipe_pkg;

  localparam int IMM_MODE_W = 4;

  // Original 3-bit codes keep their values, zero-extended to 4 bits.
  localparam logic [IMM_MODE_W-1:0] IMM_ZERO    = 4'd0;
  localparam logic [IMM_MODE_W-1:0] IMM_I       = 4'd1;
  localparam logic [IMM_MODE_W-1:0] IMM_S       = 4'd2;
  localparam logic [IMM_MODE_W-1:0] IMM_B       = 4'd3;
  localparam logic [IMM_MODE_W-1:0] IMM_U       = 4'd4;
  localparam logic [IMM_MODE_W-1:0] IMM_J       = 4'd5;
  localparam logic [IMM_MODE_W-1:0] IMM_CONST_4 = 4'd6;
  localparam logic [IMM_MODE_W-1:0] IMM_ZIMM    = 4'd7;
  localparam logic [IMM_MODE_W-1:0] IMM_SHAMT   = 4'd8;

  // Occupancy of the output/skid register pair.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction and sign/zero extension to XLEN.
// Opcode bits [6:0] never contribute to an immediate, so only [31:7] enter.
module imm_extract
  import imm_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]           instr,
  input  logic [IMM_MODE_W-1:0] mode,
  output logic [XLEN-1:0]       imm,
  output logic                  err
);

  typedef logic signed [XLEN-1:0] sxlen_t;

  // Select the field layout for the mode; signed casts do the sign extension.
  always_comb begin
    imm = '0;
    err = 1'b0;
    case (mode)
      IMM_ZERO:    imm = '0;
      IMM_I:       imm = sxlen_t'($signed(instr[31:20]));
      IMM_S:       imm = sxlen_t'($signed({instr[31:25], instr[11:7]}));
      IMM_B:       imm = sxlen_t'($signed({instr[31], instr[7], instr[30:25],
                                           instr[11:8], 1'b0}));
      IMM_U:       imm = sxlen_t'($signed({instr[31:12], 12'b0}));
      IMM_J:       imm = sxlen_t'($signed({instr[31], instr[19:12], instr[20],
                                           instr[30:21], 1'b0}));
      IMM_CONST_4: imm = XLEN'(4);
      IMM_ZIMM:    imm = XLEN'(instr[19:15]);
      IMM_SHAMT:   imm = (XLEN == 32) ? XLEN'(instr[24:20]) : XLEN'(instr[25:20]);
      default: begin
        imm = '0;
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_pipe.sv
// Registered immediate generator with PC+IMM target and a two-entry skid buffer.
// IN_READY is registered so downstream backpressure never reaches fetch combinationally.
module imm_pipe
  import imm_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  FLUSH,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [31:0]           IN_INSTR,
  input  logic [IMM_MODE_W-1:0] IN_MODE,
  input  logic [XLEN-1:0]       IN_PC,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [XLEN-1:0]       OUT_IMM,
  output logic [XLEN-1:0]       OUT_TARGET,
  output logic [31:0]           OUT_INSTR,
  output logic                  OUT_ERR
);

  skid_state_e state_reg, state_next;
  logic        in_ready_reg;

  logic [XLEN-1:0] out_imm_reg, out_tgt_reg, skid_imm_reg, skid_tgt_reg;
  logic [31:0]     out_instr_reg, skid_instr_reg;
  logic            out_err_reg, skid_err_reg;

  logic [XLEN-1:0] new_imm, new_tgt;
  logic            new_err;
  logic            accept, transfer;
  logic            load_out, load_skid, skid_to_out;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr (IN_INSTR[31:7]),
    .mode  (IN_MODE),
    .imm   (new_imm),
    .err   (new_err)
  );

  // Branch/jump target; wraps modulo 2^XLEN by construction.
  assign new_tgt  = IN_PC + new_imm;

  assign accept   = IN_VALID && in_ready_reg;
  assign transfer = OUT_VALID && OUT_READY;

  // Next-state and register-steering decisions; FLUSH overrides everything.
  always_comb begin
    state_next  = state_reg;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    if (FLUSH) begin
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            state_next = ST_ONE;
            load_out   = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && transfer) begin
            load_out = 1'b1;
          end else if (accept) begin
            state_next = ST_TWO;
            load_skid  = 1'b1;
          end else if (transfer) begin
            state_next = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (transfer) begin
            state_next  = ST_ONE;
            skid_to_out = 1'b1;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  // State register and registered ready (low only when both slots will be full).
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_reg    <= ST_EMPTY;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != ST_TWO);
    end
  end

  // Output register: loaded from the inputs or from the skid slot.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      out_imm_reg   <= '0;
      out_tgt_reg   <= '0;
      out_instr_reg <= '0;
      out_err_reg   <= 1'b0;
    end else if (load_out) begin
      out_imm_reg   <= new_imm;
      out_tgt_reg   <= new_tgt;
      out_instr_reg <= IN_INSTR;
      out_err_reg   <= new_err;
    end else if (skid_to_out) begin
      out_imm_reg   <= skid_imm_reg;
      out_tgt_reg   <= skid_tgt_reg;
      out_instr_reg <= skid_instr_reg;
      out_err_reg   <= skid_err_reg;
    end
  end

  // Skid register: holds the entry accepted while the output was stalled.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      skid_imm_reg   <= '0;
      skid_tgt_reg   <= '0;
      skid_instr_reg <= '0;
      skid_err_reg   <= 1'b0;
    end else if (load_skid) begin
      skid_imm_reg   <= new_imm;
      skid_tgt_reg   <= new_tgt;
      skid_instr_reg <= IN_INSTR;
      skid_err_reg   <= new_err;
    end
  end

  assign IN_READY   = in_ready_reg;
  assign OUT_VALID  = (state_reg != ST_EMPTY);
  assign OUT_IMM    = out_imm_reg;
  assign OUT_TARGET = out_tgt_reg;
  assign OUT_INSTR  = out_instr_reg;
  assign OUT_ERR    = out_err_reg;

endmodule

// File: tb/tb_imm_pipe.sv
// Scoreboard bench for imm_pipe at XLEN=32 (g[0]) and XLEN=64 (g[1]).
module tb_imm_pipe;

  typedef struct {
    logic [63:0] imm;
    logic [63:0] tgt;
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        iv   [2];
  logic [31:0] ii   [2];
  logic [3:0]  im   [2];
  logic [63:0] ipc  [2];
  logic        ordy [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Reference model straight from the field definitions, in 64-bit arithmetic.
  function automatic exp_t ref_model(int xl, logic [31:0] ins, logic [3:0] m, logic [63:0] pc);
    exp_t   r;
    longint v;
    logic [63:0] mask;
    r.err = 1'b0;
    case (m)
      4'd0: v = 0;
      4'd1: v = longint'($signed(ins[31:20]));
      4'd2: v = longint'($signed({ins[31:25], ins[11:7]}));
      4'd3: v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      4'd4: v = longint'($signed(ins[31:12])) * 4096;
      4'd5: v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      4'd6: v = 4;
      4'd7: v = longint'(ins[19:15]);
      4'd8: v = (xl == 32) ? longint'(ins[24:20]) : longint'(ins[25:20]);
      default: begin v = 0; r.err = 1'b1; end
    endcase
    mask    = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    r.imm   = 64'(v) & mask;
    r.tgt   = (pc + r.imm) & mask;
    r.instr = ins;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int XL = (gi == 0) ? 32 : 64;
    logic          ir, ov, oe;
    logic [XL-1:0] oimm, otgt;
    logic [31:0]   oinst;
    exp_t          q[$];

    imm_pipe #(.XLEN(XL)) dut (
      .CLK        (clk),
      .RESETN     (rst_n),
      .FLUSH      (flush),
      .IN_VALID   (iv[gi]),
      .IN_READY   (ir),
      .IN_INSTR   (ii[gi]),
      .IN_MODE    (im[gi]),
      .IN_PC      (ipc[gi][XL-1:0]),
      .OUT_VALID  (ov),
      .OUT_READY  (ordy[gi]),
      .OUT_IMM    (oimm),
      .OUT_TARGET (otgt),
      .OUT_INSTR  (oinst),
      .OUT_ERR    (oe)
    );

    // Model of held entries: handshakes observed at the edge update the queue.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q.delete();
      end else if (flush) begin
        q.delete();
      end else begin
        if (ov && ordy[gi] && q.size() > 0) void'(q.pop_front());
        if (iv[gi] && ir) q.push_back(ref_model(XL, ii[gi], im[gi], ipc[gi]));
      end
    end

    // Monitor: occupancy flags every cycle, full entry on each transfer.
    always @(negedge clk) begin
      if (rst_n) begin
        checks++;
        if (ov !== (q.size() != 0)) begin
          errors++;
          $display("FAIL x%0d out_valid actual=%b expected=%b", XL, ov, q.size() != 0);
        end
        checks++;
        if (ir !== (q.size() != 2)) begin
          errors++;
          $display("FAIL x%0d in_ready actual=%b expected=%b", XL, ir, q.size() != 2);
        end
        if (ov && ordy[gi] && q.size() > 0) begin
          checks++;
          if (64'(oimm) !== q[0].imm || 64'(otgt) !== q[0].tgt ||
              oinst !== q[0].instr || oe !== q[0].err) begin
            errors++;
            $display("FAIL x%0d xfer actual imm=%h tgt=%h instr=%h err=%b expected imm=%h tgt=%h instr=%h err=%b",
                     XL, 64'(oimm), 64'(otgt), oinst, oe, q[0].imm, q[0].tgt, q[0].instr, q[0].err);
          end else begin
            $display("x%0d xfer instr=%h imm=%h tgt=%h err=%b", XL, oinst, 64'(oimm), 64'(otgt), oe);
          end
        end
      end
    end
  end

  task automatic wait_accept(input int idx);
    logic rdy;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      rdy = (idx == 0) ? g[0].ir : g[1].ir;
      @(posedge clk);
      if (rdy) begin
        #1;
        iv[idx] = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout actual=stalled required=accepted");
    iv[idx] = 1'b0;
  endtask

  task automatic drive(input int idx, input logic [31:0] ins, input logic [3:0] m, input logic [63:0] pc);
    ii[idx]  = ins;
    im[idx]  = m;
    ipc[idx] = pc;
    iv[idx]  = 1'b1;
    wait_accept(idx);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; ii[k] = '0; im[k] = '0; ipc[k] = '0; ordy[k] = 1'b1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready32", 64'(g[0].ir), 64'd1);
    chk("rst_valid32", 64'(g[0].ov), 64'd0);
    chk("rst_imm64",   64'(g[1].oimm), 64'd0);
    chk("rst_tgt64",   64'(g[1].otgt), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // I-type and B-type wrap at XLEN=32.
    drive(0, 32'hFFF0_0093, 4'd1, 64'd0);
    @(negedge clk);
    chk("itype_valid", 64'(g[0].ov), 64'd1);
    chk("itype_imm",   64'(g[0].oimm), 64'hFFFF_FFFF);
    chk("itype_tgt",   64'(g[0].otgt), 64'hFFFF_FFFF);
    @(posedge clk); #1;
    drive(0, 32'hFE00_0EE3, 4'd3, 64'h100);
    @(negedge clk);
    chk("btype_imm", 64'(g[0].oimm), 64'hFFFF_FFFC);
    chk("btype_tgt", 64'(g[0].otgt), 64'h0000_00FC);
    @(posedge clk); #1;

    // U-type, SHAMT and illegal mode at XLEN=64.
    drive(1, 32'h8000_00B7, 4'd4, 64'd0);
    @(negedge clk);
    chk("utype64_imm", 64'(g[1].oimm), 64'hFFFF_FFFF_8000_0000);
    @(posedge clk); #1;
    drive(1, 32'h8000_00B7, 4'd8, 64'd0);
    @(negedge clk);
    chk("shamt64_imm", 64'(g[1].oimm), 64'd0);
    @(posedge clk); #1;
    drive(1, 32'h8000_00B7, 4'd12, 64'd0);
    @(negedge clk);
    chk("illegal_err", 64'(g[1].oe), 64'd1);
    chk("illegal_imm", 64'(g[1].oimm), 64'd0);
    @(posedge clk); #1;

    // Backpressure: A and B fill both slots, C waits, then all drain in order.
    ordy[0] = 1'b0;
    drive(0, 32'h0010_0093, 4'd1, 64'h10);
    drive(0, 32'h0020_0093, 4'd1, 64'h20);
    @(negedge clk);
    chk("bp_ready_low", 64'(g[0].ir), 64'd0);
    @(posedge clk); #1;
    ii[0] = 32'h0030_0093; im[0] = 4'd1; ipc[0] = 64'h30; iv[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ordy[0] = 1'b1;
    wait_accept(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bp_drained", 64'(g[0].ov), 64'd0);
    @(posedge clk); #1;

    // Flush while full, with a valid input offered in the same cycle.
    ordy[0] = 1'b0;
    drive(0, 32'h0040_0093, 4'd1, 64'h40);
    drive(0, 32'h0050_0093, 4'd1, 64'h50);
    ii[0] = 32'h0060_0093; ipc[0] = 64'h60; iv[0] = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; iv[0] = 1'b0;
    @(negedge clk);
    chk("flush_valid", 64'(g[0].ov), 64'd0);
    chk("flush_ready", 64'(g[0].ir), 64'd1);
    @(posedge clk); #1;
    ordy[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("flush_nothing_back", 64'(g[0].ov), 64'd0);
    @(posedge clk); #1;

    // Asynchronous reset while holding one entry.
    ordy[0] = 1'b0;
    drive(0, 32'h1234_5013, 4'd5, 64'h400);
    #1;
    rst_n = 1'b0;
    #1;
    chk("areset_valid", 64'(g[0].ov), 64'd0);
    chk("areset_ready", 64'(g[0].ir), 64'd1);
    chk("areset_imm",   64'(g[0].oimm), 64'd0);
    chk("areset_instr", 64'(g[0].oinst), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ordy[0] = 1'b1;
    drive(0, 32'h0000_0013, 4'd6, 64'h8);
    @(negedge clk);
    chk("post_rst_valid", 64'(g[0].ov), 64'd1);
    chk("post_rst_tgt",   64'(g[0].otgt), 64'hC);
    @(posedge clk); #1;

    // Random traffic on both widths with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        iv[k]   = ($urandom % 4) != 0;
        ii[k]   = $urandom;
        im[k]   = 4'($urandom % 16);
        ipc[k]  = {$urandom, $urandom};
        ordy[k] = ($urandom % 4) != 0;
      end
      flush = ($urandom % 40) == 0;
      @(posedge clk); #1;
    end
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b1;
    end
    flush = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("final_empty32", 64'(g[0].ov), 64'd0);
    chk("final_empty64", 64'(g[1].ov), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
